// File: rtl/u_rec_fifo.sv
// ---------------------------------------------------------------------------
// u_rec_fifo
//
// Receive-side byte buffer placed directly after the UART receiver. It watches
// the receiver's ready level, and accepts a byte only on a rising edge that
// follows a long enough low period. This rejects false starts and the short
// low pulse that the receiver gives out of reset. Accepted bytes go into a
// small synchronous FIFO, and the host drains it with a pop strobe. When a
// byte arrives and the FIFO is full, the byte is dropped and a sticky overrun
// flag is set. The receiver is never stalled.
//
// Parameters
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries
//   MIN_LOW      consecutive low cycles of rec_readyH needed before a rising
//                edge counts as a completed frame (8..255)
//
// Ports
//   sys_clk      in   system clock (16x baud, same as the receiver)
//   sys_rstH     in   synchronous active-high reset
//   rec_dataH    in   [7:0] receiver byte, sampled on a qualified push
//   rec_readyH   in   receiver ready level (low while a frame is in progress)
//   rd_reqH      in   pop strobe, one entry per cycle while not empty
//   ovr_clrH     in   clears overrunH (and drop_cntH when present)
//   fifo_dataH   out  [7:0] head entry, valid while fifo_emptyH = 0
//   fifo_emptyH  out  FIFO empty
//   fifo_fullH   out  FIFO full
//   fifo_countH  out  [DEPTH_LOG2:0] occupancy
//   overrunH     out  sticky flag: a qualified byte was dropped while full
//   drop_cntH    out  [7:0] saturating count of dropped bytes
//                     (present only when UART_RXF_DROP_CNT_EN is defined)
//
// Build option
//   UART_RXF_DROP_CNT_EN  adds the drop_cntH output and its counter
// ---------------------------------------------------------------------------
module u_rec_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int MIN_LOW    = 64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rstH,
    input  logic [7:0]            rec_dataH,
    input  logic                  rec_readyH,
    input  logic                  rd_reqH,
    input  logic                  ovr_clrH,
    output logic [7:0]            fifo_dataH,
    output logic                  fifo_emptyH,
    output logic                  fifo_fullH,
    output logic [DEPTH_LOG2:0]   fifo_countH,
    output logic                  overrunH
`ifdef UART_RXF_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cntH
`endif
);

    localparam int                  Depth    = 2 ** DEPTH_LOG2;
    localparam logic [7:0]          MinLow   = 8'(MIN_LOW);
    localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] CntOne   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

    // Frame qualifier state
    logic       prevRdy;
    logic [7:0] lowCnt;

    // FIFO state
    logic [7:0]            mem [Depth];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countReg;

    // Per-cycle decisions
    logic pushEn;   // qualified frame completion seen this cycle
    logic popEn;    // accepted pop
    logic writeEn;  // push actually stored
    logic dropEn;   // push discarded because the FIFO is full

    // The flags come only from the registered count. This keeps rd_reqH out
    // of any combinational path to them.
    assign fifo_emptyH = (countReg == '0);
    assign fifo_fullH  = (countReg == DepthCnt);
    assign fifo_countH = countReg;
    assign fifo_dataH  = mem[rdPtr];

    // NOTE: every signal assigned in always_comb gets a default value at the
    // top. Without that, a path that skips an assignment infers a latch.
    always_comb begin
        pushEn  = 1'b0;
        popEn   = 1'b0;
        writeEn = 1'b0;
        dropEn  = 1'b0;

        pushEn = rec_readyH & ~prevRdy & (lowCnt >= MinLow);
        popEn  = rd_reqH & ~fifo_emptyH;
        // When the FIFO is full, a pop in the same cycle frees the head slot,
        // so the incoming byte can still be stored.
        writeEn = pushEn & (~fifo_fullH | popEn);
        dropEn  = pushEn & fifo_fullH & ~popEn;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // All registers then sample their pre-edge values, in any statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            prevRdy <= 1'b1;
            lowCnt  <= '0;
        end else begin
            prevRdy <= rec_readyH;
            if (rec_readyH) begin
                lowCnt <= '0;
            end else if (lowCnt < MinLow) begin
                lowCnt <= lowCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
            overrunH <= 1'b0;
        end else begin
            if (writeEn) begin
                wrPtr <= wrPtr + PtrOne;
            end
            if (popEn) begin
                rdPtr <= rdPtr + PtrOne;
            end
            if (writeEn && !popEn) begin
                countReg <= countReg + CntOne;
            end else if (popEn && !writeEn) begin
                countReg <= countReg - CntOne;
            end
            // A drop takes priority over a clear in the same cycle.
            if (dropEn) begin
                overrunH <= 1'b1;
            end else if (ovr_clrH) begin
                overrunH <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is cleared on reset, although the FIFO logic
    // does not need it. This keeps fifo_dataH free of X after reset, even
    // while the head entry is don't-care.
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEn) begin
            mem[wrPtr] <= rec_dataH;
        end
    end

`ifdef UART_RXF_DROP_CNT_EN
    // Saturating drop counter. An increment takes priority over a clear, and
    // a saturated counter stays at 255 even when a clear arrives with a drop.
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            drop_cntH <= '0;
        end else if (dropEn) begin
            if (drop_cntH != 8'hFF) begin
                drop_cntH <= drop_cntH + 8'd1;
            end
        end else if (ovr_clrH) begin
            drop_cntH <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_u_rec_fifo.sv
// ---------------------------------------------------------------------------
// tb_u_rec_fifo
//
// Directed bench for u_rec_fifo with the default parameters (depth 8,
// MIN_LOW 64). Inputs change 1 time unit after each rising edge, and outputs
// are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_u_rec_fifo;

    logic       sys_clk;
    logic       sys_rstH;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       rd_reqH;
    logic       ovr_clrH;
    logic [7:0] fifo_dataH;
    logic       fifo_emptyH;
    logic       fifo_fullH;
    logic [3:0] fifo_countH;
    logic       overrunH;
`ifdef UART_RXF_DROP_CNT_EN
    logic [7:0] drop_cntH;
`endif

    int errors = 0;
    int checks = 0;

    u_rec_fifo #(
        .DEPTH_LOG2 (3),
        .MIN_LOW    (64)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rstH    (sys_rstH),
        .rec_dataH   (rec_dataH),
        .rec_readyH  (rec_readyH),
        .rd_reqH     (rd_reqH),
        .ovr_clrH    (ovr_clrH),
        .fifo_dataH  (fifo_dataH),
        .fifo_emptyH (fifo_emptyH),
        .fifo_fullH  (fifo_fullH),
        .fifo_countH (fifo_countH),
        .overrunH    (overrunH)
`ifdef UART_RXF_DROP_CNT_EN
        ,
        .drop_cntH   (drop_cntH)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Hold rec_readyH low for lowCycles clocks, then raise it with the byte
    // present. The push edge is the next clock. popAtPush asserts rd_reqH in
    // that same cycle.
    task automatic send_frame(input logic [7:0] data, input int lowCycles,
                              input logic popAtPush);
        rec_readyH = 1'b0;
        repeat (lowCycles) tick();
        rec_dataH  = data;
        rec_readyH = 1'b1;
        rd_reqH    = popAtPush;
        tick();
        rd_reqH    = 1'b0;
    endtask

    task automatic pop_one();
        rd_reqH = 1'b1;
        tick();
        rd_reqH = 1'b0;
    endtask

    task automatic test_reset();
        sys_rstH   = 1'b1;
        rec_readyH = 1'b1;
        rec_dataH  = 8'h00;
        rd_reqH    = 1'b0;
        ovr_clrH   = 1'b0;
        repeat (3) tick();
        if (fifo_emptyH !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fifo_emptyH); end
        checks++;
        if (fifo_fullH !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_fullH); end
        checks++;
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_countH); end
        checks++;
        if (overrunH !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrunH); end
        checks++;
        if (fifo_dataH !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", fifo_dataH); end
        checks++;
`ifdef UART_RXF_DROP_CNT_EN
        if (drop_cntH !== 8'd0) begin errors++; $display("FAIL reset_dropcnt got=%0d exp=0", drop_cntH); end
        checks++;
`endif
        // Release reset while the receiver shows its 1-cycle post-reset low.
        sys_rstH   = 1'b0;
        rec_readyH = 1'b0;
        tick();
        rec_readyH = 1'b1;
        repeat (3) tick();
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL postreset_glitch_count got=%0d exp=0", fifo_countH); end
        checks++;
        if (fifo_emptyH !== 1'b1) begin errors++; $display("FAIL postreset_glitch_empty got=%b exp=1", fifo_emptyH); end
        checks++;
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 150, 1'b0);
        if (fifo_countH !== 4'd1) begin errors++; $display("FAIL frame_count got=%0d exp=1", fifo_countH); end
        checks++;
        if (fifo_dataH !== 8'hA5) begin errors++; $display("FAIL frame_data got=%h exp=a5", fifo_dataH); end
        checks++;
        if (fifo_emptyH !== 1'b0) begin errors++; $display("FAIL frame_empty got=%b exp=0", fifo_emptyH); end
        checks++;
        pop_one();
        if (fifo_emptyH !== 1'b1) begin errors++; $display("FAIL frame_pop_empty got=%b exp=1", fifo_emptyH); end
        checks++;
        // A push in the same cycle as a pop on an empty FIFO is still stored.
        send_frame(8'h77, 80, 1'b1);
        if (fifo_countH !== 4'd1) begin errors++; $display("FAIL empty_pushpop_count got=%0d exp=1", fifo_countH); end
        checks++;
        if (fifo_dataH !== 8'h77) begin errors++; $display("FAIL empty_pushpop_data got=%h exp=77", fifo_dataH); end
        checks++;
        pop_one();
    endtask

    task automatic test_false_start();
        send_frame(8'h3C, 6, 1'b0);
        repeat (2) tick();
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL falsestart_count got=%0d exp=0", fifo_countH); end
        checks++;
        // One cycle short of MIN_LOW is rejected. Exactly MIN_LOW is accepted.
        send_frame(8'h63, 63, 1'b0);
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL minlow_minus1_count got=%0d exp=0", fifo_countH); end
        checks++;
        send_frame(8'h64, 64, 1'b0);
        if (fifo_countH !== 4'd1) begin errors++; $display("FAIL minlow_exact_count got=%0d exp=1", fifo_countH); end
        checks++;
        if (fifo_dataH !== 8'h64) begin errors++; $display("FAIL minlow_exact_data got=%h exp=64", fifo_dataH); end
        checks++;
        pop_one();
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 70, 1'b0);
        end
        if (fifo_countH !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", fifo_countH); end
        checks++;
        if (fifo_fullH !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", fifo_fullH); end
        checks++;
        if (overrunH !== 1'b0) begin errors++; $display("FAIL fill_no_overrun got=%b exp=0", overrunH); end
        checks++;
        send_frame(8'hFF, 70, 1'b0);
        if (overrunH !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrunH); end
        checks++;
        if (fifo_countH !== 4'd8) begin errors++; $display("FAIL ovr_count got=%0d exp=8", fifo_countH); end
        checks++;
        if (fifo_fullH !== 1'b1) begin errors++; $display("FAIL ovr_full got=%b exp=1", fifo_fullH); end
        checks++;
`ifdef UART_RXF_DROP_CNT_EN
        if (drop_cntH !== 8'd1) begin errors++; $display("FAIL ovr_dropcnt got=%0d exp=1", drop_cntH); end
        checks++;
`endif
        // Back-to-back pops: rd_reqH is held high for eight cycles.
        rd_reqH = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (fifo_dataH !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, fifo_dataH, 8'(i)); end
            checks++;
            tick();
        end
        rd_reqH = 1'b0;
        if (fifo_emptyH !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", fifo_emptyH); end
        checks++;
        // A pop on an empty FIFO is ignored.
        pop_one();
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", fifo_countH); end
        checks++;
        if (overrunH !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrunH); end
        checks++;
        ovr_clrH = 1'b1;
        tick();
        ovr_clrH = 1'b0;
        if (overrunH !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrunH); end
        checks++;
`ifdef UART_RXF_DROP_CNT_EN
        if (drop_cntH !== 8'd0) begin errors++; $display("FAIL dropcnt_clear got=%0d exp=0", drop_cntH); end
        checks++;
`endif
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 70, 1'b0);
        end
        send_frame(8'hFF, 70, 1'b1);
        if (fifo_countH !== 4'd8) begin errors++; $display("FAIL fullpp_count got=%0d exp=8", fifo_countH); end
        checks++;
        if (overrunH !== 1'b0) begin errors++; $display("FAIL fullpp_overrun got=%b exp=0", overrunH); end
        checks++;
        if (fifo_dataH !== 8'h02) begin errors++; $display("FAIL fullpp_head got=%h exp=02", fifo_dataH); end
        checks++;
        for (int i = 2; i <= 9; i++) begin
            logic [7:0] exp;
            exp = (i == 9) ? 8'hFF : 8'(i);
            if (fifo_dataH !== exp) begin errors++; $display("FAIL fullpp_drain[%0d] got=%h exp=%h", i, fifo_dataH, exp); end
            checks++;
            pop_one();
        end
        if (fifo_emptyH !== 1'b1) begin errors++; $display("FAIL fullpp_empty got=%b exp=1", fifo_emptyH); end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 70, 1'b0);
        rec_readyH = 1'b0;
        repeat (70) tick();
        sys_rstH = 1'b1;
        tick();
        sys_rstH = 1'b0;
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", fifo_countH); end
        checks++;
        // The receiver stays low for 10 more cycles and then rises. The
        // partial low period ended by reset must not qualify this edge.
        send_frame(8'h22, 10, 1'b0);
        repeat (2) tick();
        if (fifo_countH !== 4'd0) begin errors++; $display("FAIL midrst_rise_count got=%0d exp=0", fifo_countH); end
        checks++;
        send_frame(8'h5A, 150, 1'b0);
        if (fifo_countH !== 4'd1) begin errors++; $display("FAIL midrst_next_count got=%0d exp=1", fifo_countH); end
        checks++;
        if (fifo_dataH !== 8'h5A) begin errors++; $display("FAIL midrst_next_data got=%h exp=5a", fifo_dataH); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_false_start();
        test_fill_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/u_rec_fifo.md
# u_rec_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver and consumes its parallel byte and ready level. It qualifies each completed frame from the ready level, rejects false-start glitches, and queues bytes in a small synchronous FIFO. Host logic drains the FIFO with a pop strobe. Overruns are flagged rather than blocking the receiver.

## Interface
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 entries (8).
- MIN_LOW, 64: minimum consecutive low cycles on rec_readyH before a rising edge counts as a completed frame; range 8..255.
- sys_clk  in  1  system clock, same 16x-baud clock as the receiver.
- sys_rstH  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- rec_dataH  in  8  receiver parallel byte; sampled only on a qualified push.
- rec_readyH  in  1  receiver ready level: high when idle or frame done, low while a frame is in progress.
- rd_reqH  in  1  pop strobe; one entry removed per cycle high when not empty.
- fifo_dataH  out  8  head entry; valid while fifo_emptyH=0.
- fifo_emptyH  out  1  FIFO empty.
- fifo_fullH  out  1  FIFO full.
- fifo_countH  out  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2.
- overrunH  out  1  sticky: a qualified byte was dropped because the FIFO was full.
- ovr_clrH  in  1  clears overrunH.

## Operation
- Frame qualifier:
  - prev_rdyH registers rec_readyH.
  - low_cntH is 8 bits. It increments while rec_readyH=0, saturates at MIN_LOW, and clears when rec_readyH=1.
  - pushH = rec_readyH & ~prev_rdyH & (low_cntH >= MIN_LOW).
  - A rising edge after a shorter low period is discarded with no side effects. This covers receiver false starts of about 6 cycles and the receiver's 1-cycle post-reset low.
- Push writes rec_dataH into mem[wr_ptr] and increments wr_ptr modulo depth.
- Pop: rd_reqH & ~fifo_emptyH increments rd_ptr. fifo_dataH = mem[rd_ptr] is read combinationally from the register array.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Occupancy is tracked in a separate counter.
- Simultaneous events:
  - Push and pop while not empty and not full: both happen, count unchanged.
  - Push and pop while full: both happen, the byte is accepted, count unchanged, no overrun.
  - Push and pop while empty: push happens, pop ignored, count becomes 1.
  - Push while full without pop: byte dropped, pointers unchanged, overrunH set.
  - Pop while empty: ignored.
- overrunH is set by a drop and cleared by ovr_clrH. If both occur in the same cycle, set wins.
- Reset:
  - prev_rdyH=1, low_cntH=0, pointers=0, count=0.
  - fifo_emptyH=1, fifo_fullH=0, fifo_countH=0, overrunH=0.
  - fifo_dataH is don't-care, but memory is not reset, so drive X-free by resetting mem to 0.
- Reset asserted mid-frame discards partial state. The next frame is accepted only after a fresh MIN_LOW low period.

## Timing
- A push is evaluated in the cycle rec_readyH is first seen high. rec_dataH is stable then because the receiver's shift register is idle.
- Push at edge N: fifo_emptyH falls, fifo_countH increments and fifo_dataH shows the byte after edge N (0-cycle read latency from the count update).
- Pop at edge N: fifo_dataH shows the next entry after edge N. Back-to-back pops are legal every cycle.
- Flags and count are registered or derived from registered state; there is no combinational path from rd_reqH to the flags.
- Minimum spacing of real frames is about 150 cycles, so push rate is never a concern. Depth covers host latency.

## Configuration
- UART_RXF_DROP_CNT_EN defined:
  - Adds output drop_cntH [7:0], reset 0.
  - drop_cntH increments on each dropped byte and saturates at 255.
  - ovr_clrH also clears it; increment wins over clear in the same cycle.
- Not defined: the port and counter are absent, and overrunH behaviour is unchanged.

## Test plan
- Reset release with rec_readyH 0 for 1 cycle then 1 -> no push; fifo_countH=0, fifo_emptyH=1.
- Frame: rec_readyH low 150 cycles, rec_dataH=8'hA5, then high -> fifo_countH=1 and fifo_dataH=8'hA5 one cycle later; rd_reqH pulse -> fifo_emptyH=1.
- False start: rec_readyH low 6 cycles then high with rec_dataH=8'h3C -> no push, count stays 0.
- Fill 8 frames 8'h01..8'h08, then 9th frame 8'hFF -> fifo_fullH=1, overrunH=1, drop_cntH=1 when enabled; pops return 01..08 in order.
- Full FIFO with 9th qualified push and rd_reqH in the same cycle -> 8'h01 popped, 8'hFF accepted, count stays 8, overrunH=0.
- Assert sys_rstH mid-frame (low 70 cycles), release, rec_readyH rises 10 cycles later -> no push; the next 150-cycle frame pushes normally.
